cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Controller FSM directly upstream of the cache memory array (32 lines x 4 words; entry = {valid, tag[2:0], data[31:0]}).
- Takes CPU word-address read/write requests and resolves hit/miss from the array's read data.
- On a read miss, refills a full line from main memory. Writes are write-through with no-write-allocate.
- Drives the array's read/write addresses, write enable and 36-bit write data, and stalls the CPU while memory traffic is outstanding.

Parameters:
TAG_W, 3, tag width (cpu_addr[9:7])
IDX_W, 5, line index width (cpu_addr[6:2])
OFF_W, 2, word offset width (cpu_addr[1:0]); 4 words per line

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
cpu_addr  input  10  word address {tag, index, offset}; held stable by CPU while stall=1
cpu_rd_req  input  1  read request
cpu_wr_req  input  1  write request
cpu_wdata  input  32  write data
cpu_rdata  output  32  read data, valid when cpu_rd_req=1 and stall=0
stall  output  1  CPU must hold request/address
cache_r_addrs  output  7  array read address {index, word}
cache_w_addrs  output  7  array data write address {index, word}
cache_we  output  1  array write enable (valid+tag+data written together)
cache_wd  output  36  {valid, tag, data}
cache_rd  input  36  array read data for cache_r_addrs (combinational read)
mem_addr  output  10  main-memory word address
mem_rd_req  output  1  memory read request, level, held until mem_ready
mem_wr_req  output  1  memory write request, level, held until mem_ready
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid with mem_ready
mem_ready  input  1  one-cycle completion pulse for the current beat

Behaviour:
- hit = cache_rd[35] & (cache_rd[34:32] == cpu_addr[9:7]).
- The array writes valid/tag at cache_r_addrs[6:2]. During every cache_we cycle, cache_r_addrs == cache_w_addrs.
- States: IDLE, WRITE_THRU, REFILL, RESPOND. 2-bit beat counter cnt.
- Reset (reset=0 at clk edge): state=IDLE, cnt=0, all outputs 0 except cache_r_addrs = cpu_addr[6:0] (combinational). Applies mid-operation too: an in-flight memory request is dropped.
- IDLE: cache_r_addrs = cpu_addr[6:0].
  - No request: stall=0.
  - rd & hit: cpu_rdata = cache_rd[31:0], stall=0, stay IDLE (0 added cycles).
  - rd & miss: stall=1, cnt<=0, go REFILL.
  - wr (has priority if rd and wr are both asserted): stall=1. If hit, cache_we=1 this cycle with cache_wd={1, tag, cpu_wdata} at cpu_addr[6:0]; if miss, no array write. Latch address/data, go WRITE_THRU.
- WRITE_THRU: mem_wr_req=1, mem_addr=latched addr, mem_wdata=latched data, stall=1. On mem_ready, go IDLE with stall=0 in the same cycle, so the write retires.
- REFILL: mem_rd_req=1, mem_addr={tag, index, cnt}, stall=1, cache_r_addrs=cache_w_addrs={index, cnt}.
  - On mem_ready: cache_we=1, cache_wd={cnt==3, tag, mem_rdata}, cnt<=cnt+1.
  - Valid is written 0 on beats 0-2 and 1 only on beat 3, so a partially refilled or reset-aborted line is never seen as valid.
  - After beat 3, go RESPOND.
  - Without mem_ready: hold all outputs, no array write.
- RESPOND: cache_r_addrs=cpu_addr[6:0]; the array now hits. cpu_rdata=cache_rd[31:0], stall=0, go IDLE.
- Read-miss latency: 4 memory beats + 1 RESPOND cycle. Back-to-back mem_ready gives 5 stall cycles.
- Fill order is always word 0..3. The critical word is not forwarded.
- mem_rd_req and mem_wr_req are never asserted together. cache_we never asserts outside the cases above.
- The controller never clears valid bits; array-level reset owns that.

Test Plan:
- Reset, then read 0x0A5 with the line invalid, mem returns 0x100+word on consecutive-cycle mem_ready -> 4 array writes to 0x24..0x27 with valid=0,0,0,1; stall high 5 cycles; cpu_rdata=0x101.
- Read 0x0A6 right after -> hit, stall=0 the same cycle, cpu_rdata=0x102, no mem request.
- Write 0x0A7 data 0xDEADBEEF (hit) -> cache_we in the IDLE cycle, cache_wd=0x9_DEADBEEF at 0x27; mem_wr_req held until mem_ready after 3 cycles; a subsequent read returns 0xDEADBEEF.
- Write 0x3E4 (miss) -> no cache_we, one mem write, a later read of 0x3E4 still misses.
- Assert reset during the REFILL beat-2 wait -> next cycle state IDLE, mem_rd_req=0, stall=0; line 0x1D read shows valid=0.
- Conflict miss: read 0x125 after the 0x0A5 line is filled (same index 9, tag 2 vs 1) -> refill replaces the tag, cache_wd[34:32]=2.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Controller between the CPU and a 32-line x 4-word cache array whose
//   entries are {valid, tag, data}. Reads hit from the array in zero added
//   cycles; read misses refill the whole line (words 0..3) from main memory
//   and then answer from the array. Writes are write-through with
//   no-write-allocate: a hit updates the array in the request cycle, and
//   every write is forwarded to memory.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-low reset
//   cpu_addr         word address {tag, index, offset}, stable while stall=1
//   cpu_rd_req       read request
//   cpu_wr_req       write request (wins over a simultaneous read)
//   cpu_wdata        write data
//   cpu_rdata        read data, valid with cpu_rd_req=1 and stall=0
//   stall            CPU must hold its request and address
//   cache_r_addrs    array read address {index, word}; valid/tag row select
//   cache_w_addrs    array data write address {index, word}
//   cache_we         array write enable (valid, tag and data together)
//   cache_wd         array write data {valid, tag, data}
//   cache_rd         array read data at cache_r_addrs (combinational)
//   mem_addr         main-memory word address
//   mem_rd_req       memory read request, held until mem_ready
//   mem_wr_req       memory write request, held until mem_ready
//   mem_wdata        memory write data
//   mem_rdata        memory read data, valid with mem_ready
//   mem_ready        one-cycle completion pulse per beat
module cache_refill_ctrl #(
  parameter int TAG_W = 3,
  parameter int IDX_W = 5,
  parameter int OFF_W = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [TAG_W+IDX_W+OFF_W-1:0]     cpu_addr,
  input  logic                             cpu_rd_req,
  input  logic                             cpu_wr_req,
  input  logic [31:0]                      cpu_wdata,
  output logic [31:0]                      cpu_rdata,
  output logic                             stall,
  output logic [IDX_W+OFF_W-1:0]           cache_r_addrs,
  output logic [IDX_W+OFF_W-1:0]           cache_w_addrs,
  output logic                             cache_we,
  output logic [TAG_W+32:0]                cache_wd,
  input  logic [TAG_W+32:0]                cache_rd,
  output logic [TAG_W+IDX_W+OFF_W-1:0]     mem_addr,
  output logic                             mem_rd_req,
  output logic                             mem_wr_req,
  output logic [31:0]                      mem_wdata,
  input  logic [31:0]                      mem_rdata,
  input  logic                             mem_ready
);

  localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
  localparam int LINE_W  = IDX_W + OFF_W;
  localparam int ENTRY_W = 1 + TAG_W + 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_THRU,
    REFILL,
    RESPOND
  } state_t;

  state_t              state;
  logic [OFF_W-1:0]    cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_data;
  logic                hit;

  assign hit = cache_rd[ENTRY_W-1] &
               (cache_rd[ENTRY_W-2 -: TAG_W] == cpu_addr[ADDR_W-1 -: TAG_W]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_wr_req) begin
            lat_addr <= cpu_addr;
            lat_data <= cpu_wdata;
            state    <= WRITE_THRU;
          end else if (cpu_rd_req && !hit) begin
            lat_addr <= cpu_addr;
            cnt      <= '0;
            state    <= REFILL;
          end
        end
        WRITE_THRU: begin
          if (mem_ready) state <= IDLE;
        end
        REFILL: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) state <= RESPOND;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded combinationally from state: hit data, the write-hit
  // array update and the write-through release all land in the same cycle
  // as the condition that causes them. Reset forces them low (except the
  // read address, which keeps tracking the CPU) so an in-flight memory
  // request is dropped immediately.
  always_comb begin
    cpu_rdata     = '0;
    stall         = 1'b0;
    cache_r_addrs = cpu_addr[LINE_W-1:0];
    cache_w_addrs = '0;
    cache_we      = 1'b0;
    cache_wd      = '0;
    mem_addr      = '0;
    mem_rd_req    = 1'b0;
    mem_wr_req    = 1'b0;
    mem_wdata     = '0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          cache_w_addrs = cpu_addr[LINE_W-1:0];
          if (cpu_wr_req) begin
            stall = 1'b1;
            if (hit) begin
              cache_we = 1'b1;
              cache_wd = {1'b1, cpu_addr[ADDR_W-1 -: TAG_W], cpu_wdata};
            end
          end else if (cpu_rd_req) begin
            if (hit) cpu_rdata = cache_rd[31:0];
            else     stall     = 1'b1;
          end
        end
        WRITE_THRU: begin
          cache_w_addrs = cpu_addr[LINE_W-1:0];
          mem_wr_req    = 1'b1;
          mem_addr      = lat_addr;
          mem_wdata     = lat_data;
          stall         = !mem_ready;
        end
        REFILL: begin
          cache_r_addrs = {lat_addr[LINE_W-1:OFF_W], cnt};
          cache_w_addrs = {lat_addr[LINE_W-1:OFF_W], cnt};
          mem_rd_req    = 1'b1;
          mem_addr      = {lat_addr[ADDR_W-1:OFF_W], cnt};
          stall         = 1'b1;
          // Valid is set only by the final beat so a partial or aborted
          // refill never leaves a line that looks valid.
          if (mem_ready) begin
            cache_we = 1'b1;
            cache_wd = {(cnt == '1), lat_addr[ADDR_W-1 -: TAG_W], mem_rdata};
          end
        end
        RESPOND: begin
          cache_w_addrs = cpu_addr[LINE_W-1:0];
          cpu_rdata     = cache_rd[31:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: a behavioural cache array and
// CPU/memory stimulus tables, plus hand-written multi-cycle sequences.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  cpu_addr;
  logic        cpu_rd_req;
  logic        cpu_wr_req;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [6:0]  cache_r_addrs;
  logic [6:0]  cache_w_addrs;
  logic        cache_we;
  logic [35:0] cache_wd;
  logic [35:0] cache_rd;
  logic [9:0]  mem_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  cache_refill_ctrl #(.TAG_W(3), .IDX_W(5), .OFF_W(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .cache_r_addrs(cache_r_addrs), .cache_w_addrs(cache_w_addrs),
    .cache_we(cache_we), .cache_wd(cache_wd), .cache_rd(cache_rd),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache array model: data per word, valid/tag per line.
  logic [31:0] arr_data [128];
  logic [31:0] arr_valid;
  logic [2:0]  arr_tag  [32];

  assign cache_rd = {arr_valid[cache_r_addrs[6:2]], arr_tag[cache_r_addrs[6:2]],
                     arr_data[cache_r_addrs]};

  always @(posedge clk) begin
    if (cache_we) begin
      arr_data[cache_w_addrs]        <= cache_wd[31:0];
      arr_valid[cache_r_addrs[6:2]]  <= cache_wd[35];
      arr_tag[cache_r_addrs[6:2]]    <= cache_wd[34:32];
    end
  end

  typedef struct {
    logic        rst;
    logic [9:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] mrdata;
    logic        e_stall;
    logic        e_we;
    logic [35:0] e_wd;
    logic [6:0]  e_ra;
    logic [6:0]  e_wa;
    logic        e_mrd;
    logic        e_mwr;
    logic [9:0]  e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];
  int checks;
  int failures;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [9:0] a, input logic rd, input logic wr,
                     input logic [31:0] wd, input logic rdy, input logic [31:0] mrd,
                     input logic e_stall, input logic e_we, input logic [35:0] e_wd,
                     input logic [6:0] e_ra, input logic [6:0] e_wa, input logic e_mrd,
                     input logic e_mwr, input logic [9:0] e_maddr, input logic [31:0] e_mwdata,
                     input logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.rdy = rdy; v.mrdata = mrd;
    v.e_stall = e_stall; v.e_we = e_we; v.e_wd = e_wd; v.e_ra = e_ra; v.e_wa = e_wa;
    v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [9:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] mrd);
    reset = rst; cpu_addr = a; cpu_rd_req = rd; cpu_wr_req = wr; cpu_wdata = wd;
    mem_ready = rdy; mem_rdata = mrd;
  endtask

  initial begin
    int cyc;
    int wait_cnt;
    int writes;
    logic done;
    logic [35:0] last_wd;

    checks = 0;
    failures = 0;
    arr_valid = '0;
    for (int i = 0; i < 128; i++) arr_data[i] = '0;
    for (int i = 0; i < 32; i++) arr_tag[i] = '0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);

    //   rst addr   rd wr wdata          rdy mrdata   stall we wd                ra    wa    mrd mwr maddr  mwdata         rdata
    // reset state, reset dominates a request
    add(0, 'h0A5, 0, 0, 0,             0, 0,       0, 0, 0,               'h25, 'h00, 0, 0, 'h000, 0,             0);
    add(0, 'h0A5, 1, 0, 0,             0, 0,       0, 0, 0,               'h25, 'h00, 0, 0, 'h000, 0,             0);
    // read miss 0x0A5, four back-to-back beats, RESPOND returns word 1
    add(1, 'h0A5, 1, 0, 0,             0, 0,       1, 0, 0,               'h25, 'h25, 0, 0, 'h000, 0,             0);
    add(1, 'h0A5, 1, 0, 0,             1, 'h100,   1, 1, 36'h1_0000_0100, 'h24, 'h24, 1, 0, 'h0A4, 0,             0);
    add(1, 'h0A5, 1, 0, 0,             1, 'h101,   1, 1, 36'h1_0000_0101, 'h25, 'h25, 1, 0, 'h0A5, 0,             0);
    add(1, 'h0A5, 1, 0, 0,             1, 'h102,   1, 1, 36'h1_0000_0102, 'h26, 'h26, 1, 0, 'h0A6, 0,             0);
    add(1, 'h0A5, 1, 0, 0,             1, 'h103,   1, 1, 36'h9_0000_0103, 'h27, 'h27, 1, 0, 'h0A7, 0,             0);
    add(1, 'h0A5, 1, 0, 0,             0, 0,       0, 0, 0,               'h25, 'h25, 0, 0, 'h000, 0,             'h101);
    // read hit 0x0A6
    add(1, 'h0A6, 1, 0, 0,             0, 0,       0, 0, 0,               'h26, 'h26, 0, 0, 'h000, 0,             'h102);
    // write hit 0x0A7, memory completes on third cycle
    add(1, 'h0A7, 0, 1, 'hDEADBEEF,    0, 0,       1, 1, 36'h9_DEAD_BEEF, 'h27, 'h27, 0, 0, 'h000, 0,             0);
    add(1, 'h0A7, 0, 1, 'hDEADBEEF,    0, 0,       1, 0, 0,               'h27, 'h27, 0, 1, 'h0A7, 'hDEADBEEF,   0);
    add(1, 'h0A7, 0, 1, 'hDEADBEEF,    0, 0,       1, 0, 0,               'h27, 'h27, 0, 1, 'h0A7, 'hDEADBEEF,   0);
    add(1, 'h0A7, 0, 1, 'hDEADBEEF,    1, 0,       0, 0, 0,               'h27, 'h27, 0, 1, 'h0A7, 'hDEADBEEF,   0);
    add(1, 'h0A7, 1, 0, 0,             0, 0,       0, 0, 0,               'h27, 'h27, 0, 0, 'h000, 0,             'hDEADBEEF);
    // write miss 0x3E4: no array write; later read still misses, then reset aborts
    add(1, 'h3E4, 0, 1, 'h12345678,    0, 0,       1, 0, 0,               'h64, 'h64, 0, 0, 'h000, 0,             0);
    add(1, 'h3E4, 0, 1, 'h12345678,    1, 0,       0, 0, 0,               'h64, 'h64, 0, 1, 'h3E4, 'h12345678,   0);
    add(1, 'h3E4, 1, 0, 0,             0, 0,       1, 0, 0,               'h64, 'h64, 0, 0, 'h000, 0,             0);
    add(0, 'h3E4, 1, 0, 0,             0, 0,       0, 0, 0,               'h64, 'h00, 0, 0, 'h000, 0,             0);
    // read miss 0x174 (line 0x1D), reset during beat-2 wait
    add(1, 'h174, 1, 0, 0,             0, 0,       1, 0, 0,               'h74, 'h74, 0, 0, 'h000, 0,             0);
    add(1, 'h174, 1, 0, 0,             1, 'h200,   1, 1, 36'h2_0000_0200, 'h74, 'h74, 1, 0, 'h174, 0,             0);
    add(1, 'h174, 1, 0, 0,             1, 'h201,   1, 1, 36'h2_0000_0201, 'h75, 'h75, 1, 0, 'h175, 0,             0);
    add(1, 'h174, 1, 0, 0,             0, 0,       1, 0, 0,               'h76, 'h76, 1, 0, 'h176, 0,             0);
    add(0, 'h174, 1, 0, 0,             0, 0,       0, 0, 0,               'h74, 'h00, 0, 0, 'h000, 0,             0);
    add(1, 'h174, 0, 0, 0,             0, 0,       0, 0, 0,               'h74, 'h74, 0, 0, 'h000, 0,             0);
    add(1, 'h174, 1, 0, 0,             0, 0,       1, 0, 0,               'h74, 'h74, 0, 0, 'h000, 0,             0);
    add(0, 'h174, 0, 0, 0,             0, 0,       0, 0, 0,               'h74, 'h00, 0, 0, 'h000, 0,             0);
    // conflict miss 0x125 on line 9: tag 1 replaced by tag 2
    add(1, 'h125, 1, 0, 0,             0, 0,       1, 0, 0,               'h25, 'h25, 0, 0, 'h000, 0,             0);
    add(1, 'h125, 1, 0, 0,             1, 'h300,   1, 1, 36'h2_0000_0300, 'h24, 'h24, 1, 0, 'h124, 0,             0);
    add(1, 'h125, 1, 0, 0,             1, 'h301,   1, 1, 36'h2_0000_0301, 'h25, 'h25, 1, 0, 'h125, 0,             0);
    add(1, 'h125, 1, 0, 0,             1, 'h302,   1, 1, 36'h2_0000_0302, 'h26, 'h26, 1, 0, 'h126, 0,             0);
    add(1, 'h125, 1, 0, 0,             1, 'h303,   1, 1, 36'hA_0000_0303, 'h27, 'h27, 1, 0, 'h127, 0,             0);
    add(1, 'h125, 1, 0, 0,             0, 0,       0, 0, 0,               'h25, 'h25, 0, 0, 'h000, 0,             'h301);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
            vecs[i].rdy, vecs[i].mrdata);
      #1;
      chk($sformatf("v%0d_stall", i),  {35'd0, stall},       {35'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_we", i),     {35'd0, cache_we},    {35'd0, vecs[i].e_we});
      chk($sformatf("v%0d_wd", i),     cache_wd,             vecs[i].e_wd);
      chk($sformatf("v%0d_raddr", i),  {29'd0, cache_r_addrs}, {29'd0, vecs[i].e_ra});
      chk($sformatf("v%0d_waddr", i),  {29'd0, cache_w_addrs}, {29'd0, vecs[i].e_wa});
      chk($sformatf("v%0d_mrd", i),    {35'd0, mem_rd_req},  {35'd0, vecs[i].e_mrd});
      chk($sformatf("v%0d_mwr", i),    {35'd0, mem_wr_req},  {35'd0, vecs[i].e_mwr});
      chk($sformatf("v%0d_maddr", i),  {26'd0, mem_addr},    {26'd0, vecs[i].e_maddr});
      chk($sformatf("v%0d_mwdata", i), {4'd0, mem_wdata},    {4'd0, vecs[i].e_mwdata});
      chk($sformatf("v%0d_rdata", i),  {4'd0, cpu_rdata},    {4'd0, vecs[i].e_rdata});
    end

    // Simultaneous read+write: write wins, hits line 9 (tag 2), variable memory delay.
    @(negedge clk);
    drive(1'b1, 'h126, 1'b1, 1'b1, 'hCAFEF00D, 1'b0, '0);
    #1;
    chk("prio_we", {35'd0, cache_we}, 36'd1);
    chk("prio_wd", cache_wd, 36'hA_CAFE_F00D);
    chk("prio_stall", {35'd0, stall}, 36'd1);
    chk("prio_rdata", {4'd0, cpu_rdata}, 36'd0);
    done = 1'b0;
    wait_cnt = $urandom_range(0, 3);
    for (cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (mem_wr_req && wait_cnt == 0) begin
        chk("prio_maddr", {26'd0, mem_addr}, 36'h126);
        chk("prio_mwdata", {4'd0, mem_wdata}, 36'hCAFE_F00D);
        chk("prio_no_mrd", {35'd0, mem_rd_req}, 36'd0);
        mem_ready = 1'b1;
        #1;
        chk("prio_release", {35'd0, stall}, 36'd0);
        done = 1'b1;
      end else if (mem_wr_req) begin
        wait_cnt--;
      end
    end
    chk("prio_timeout", {35'd0, done}, 36'd1);
    @(negedge clk);
    drive(1'b1, 'h126, 1'b1, 1'b0, '0, 1'b0, '0);
    #1;
    chk("prio_readback", {4'd0, cpu_rdata}, 36'hCAFE_F00D);
    chk("prio_readback_stall", {35'd0, stall}, 36'd0);

    // Read miss 0x2B0 (tag 5, line 12) with random gaps between beats.
    @(negedge clk);
    drive(1'b1, 'h2B0, 1'b1, 1'b0, '0, 1'b0, '0);
    done = 1'b0;
    writes = 0;
    last_wd = '0;
    wait_cnt = $urandom_range(0, 2);
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc != 0) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (!stall) begin
        chk("gap_rdata", {4'd0, cpu_rdata}, 36'h400);
        done = 1'b1;
      end else if (mem_rd_req) begin
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = 32'h400 + {30'd0, mem_addr[1:0]};
          wait_cnt = $urandom_range(0, 2);
          #1;
          if (cache_we) begin
            writes++;
            last_wd = cache_wd;
          end
        end else begin
          wait_cnt--;
        end
      end
    end
    chk("gap_timeout", {35'd0, done}, 36'd1);
    chk("gap_writes", 36'(writes), 36'd4);
    chk("gap_last_wd", last_wd, 36'hD_0000_0403);

    @(negedge clk);
    drive(1'b1, 'h2B3, 1'b1, 1'b0, '0, 1'b0, '0);
    #1;
    chk("gap_hit_w3", {4'd0, cpu_rdata}, 36'h403);
    chk("line1d_valid", {35'd0, arr_valid[29]}, 36'd0);
    chk("line9_tag", {33'd0, arr_tag[9]}, 36'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
